// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and constants for the Z80 bus responder
package z80_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } bus_state_e;

   typedef enum logic [2:0] {
      CLS_NONE    = 3'd0,
      CLS_MEMRD   = 3'd1,
      CLS_MEMWR   = 3'd2,
      CLS_IORD    = 3'd3,
      CLS_IOWR    = 3'd4,
      CLS_INTA    = 3'd5,
      CLS_REFRESH = 3'd6
   } cycle_cls_e;

   // di value after reset, and the value a CPU sees from an undriven bus
   localparam logic [7:0] DI_RESET = 8'h00;
   localparam logic [7:0] DI_FLOAT = 8'hFF;

   function automatic logic cls_is_io(input cycle_cls_e c);
      return (c == CLS_IORD) || (c == CLS_IOWR);
   endfunction

   function automatic logic cls_is_write(input cycle_cls_e c);
      return (c == CLS_MEMWR) || (c == CLS_IOWR);
   endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// rtl/z80_cycle_decode.sv - classifies the Z80 bus strobes into one cycle class
module z80_cycle_decode
   import z80_bus_pkg::*;
(
   input  logic       m1_n,
   input  logic       mreq_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       rfsh_n,
   output cycle_cls_e cls
);

   // First matching class wins; refresh is excluded from MEMRD so an M1
   // refresh slot never looks like a memory read.
   always_comb begin
      cls = CLS_NONE;
      if (!mreq_n && !rd_n && rfsh_n) begin
         cls = CLS_MEMRD;
      end else if (!mreq_n && !wr_n) begin
         cls = CLS_MEMWR;
      end else if (!iorq_n && !rd_n && m1_n) begin
         cls = CLS_IORD;
      end else if (!iorq_n && !wr_n) begin
         cls = CLS_IOWR;
      end else if (!iorq_n && !m1_n) begin
         cls = CLS_INTA;
      end else if (!rfsh_n) begin
         cls = CLS_REFRESH;
      end
   end

endmodule

// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - bridges Z80 bus cycles to a request/ack backing store
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter logic [7:0]  INT_VECTOR = 8'hFF,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned IO_ENABLE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   output logic [7:0]  di,
   output logic        wait_n,
   output logic        bk_req,
   output logic        bk_we,
   output logic        bk_io,
   output logic [15:0] bk_addr,
   output logic [7:0]  bk_wdata,
   input  logic        bk_ack,
   input  logic [7:0]  bk_rdata,
   output logic        bus_err
);

   localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
   localparam logic             IO_EN     = (IO_ENABLE != 0);

   cycle_cls_e       cls;
   bus_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bk_we_q, bk_we_d;
   logic             bk_io_q, bk_io_d;
   logic [15:0]      bk_addr_q, bk_addr_d;
   logic [7:0]       bk_wdata_q, bk_wdata_d;
   logic [7:0]       di_q, di_d;
   logic             bus_err_q, bus_err_d;
   logic             stall;

   z80_cycle_decode u_decode (
      .m1_n   (m1_n),
      .mreq_n (mreq_n),
      .iorq_n (iorq_n),
      .rd_n   (rd_n),
      .wr_n   (wr_n),
      .rfsh_n (rfsh_n),
      .cls    (cls)
   );

   // Next-state logic: capture a bus cycle in IDLE, wait for ack or timeout
   // in REQ, then hold the result in HOLD until the CPU releases its strobes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bk_we_d    = bk_we_q;
      bk_io_d    = bk_io_q;
      bk_addr_d  = bk_addr_q;
      bk_wdata_d = bk_wdata_q;
      di_d       = di_q;
      bus_err_d  = 1'b0;
      stall      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            case (cls)
               CLS_MEMRD, CLS_MEMWR, CLS_IORD, CLS_IOWR: begin
                  stall = 1'b1;
                  if (cls_is_io(cls) && !IO_EN) begin
                     // Disabled I/O: reads see a floating bus, writes vanish.
                     if (cls == CLS_IORD) begin
                        di_d = DI_FLOAT;
                     end
                     state_d = ST_HOLD;
                  end else begin
                     bk_we_d    = cls_is_write(cls);
                     bk_io_d    = cls_is_io(cls);
                     bk_addr_d  = A;
                     bk_wdata_d = dout;
                     cnt_d      = '0;
                     state_d    = ST_REQ;
                  end
               end
               CLS_INTA: begin
                  stall   = 1'b1;
                  di_d    = INT_VECTOR;
                  state_d = ST_HOLD;
               end
               default: ;
            endcase
         end
         ST_REQ: begin
            stall = 1'b1;
            if (bk_ack) begin
               if (!bk_we_q) begin
                  di_d = bk_rdata;
               end
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_LIMIT) begin
                  di_d      = DI_FLOAT;
                  bus_err_d = 1'b1;
                  state_d   = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if ((cls == CLS_NONE) || (cls == CLS_REFRESH)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and captured-request registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bk_we_q    <= 1'b0;
         bk_io_q    <= 1'b0;
         bk_addr_q  <= '0;
         bk_wdata_q <= '0;
         di_q       <= DI_RESET;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bk_we_q    <= bk_we_d;
         bk_io_q    <= bk_io_d;
         bk_addr_q  <= bk_addr_d;
         bk_wdata_q <= bk_wdata_d;
         di_q       <= di_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign bk_req   = (state_q == ST_REQ);
   assign bk_we    = bk_we_q;
   assign bk_io    = bk_io_q;
   assign bk_addr  = bk_addr_q;
   assign bk_wdata = bk_wdata_q;
   assign di       = di_q;
   assign bus_err  = bus_err_q;
   assign wait_n   = ~stall;

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb/tb_z80_bus_responder.sv - self-checking bench for z80_bus_responder
module tb_z80_bus_responder;

   localparam int TMO    = 16;
   localparam int WINDOW = TMO + 4;

   localparam int C_NONE    = 0;
   localparam int C_FETCH   = 1;
   localparam int C_MEMRD   = 2;
   localparam int C_MEMWR   = 3;
   localparam int C_IORD    = 4;
   localparam int C_IOWR    = 5;
   localparam int C_INTA    = 6;
   localparam int C_REFRESH = 7;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] A;
   logic [7:0]  dout;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
   logic        bk_ack;
   logic [7:0]  bk_rdata;

   logic [7:0]  di, n_di;
   logic        wait_n, n_wait_n;
   logic        bk_req, n_bk_req;
   logic        bk_we, n_bk_we;
   logic        bk_io, n_bk_io;
   logic [15:0] bk_addr, n_bk_addr;
   logic [7:0]  bk_wdata, n_bk_wdata;
   logic        bus_err, n_bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   z80_bus_responder #(.INT_VECTOR(8'hFF), .TIMEOUT(TMO), .IO_ENABLE(1)) dut (
      .clk(clk), .reset(reset), .A(A), .dout(dout),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .di(di), .wait_n(wait_n), .bk_req(bk_req), .bk_we(bk_we), .bk_io(bk_io),
      .bk_addr(bk_addr), .bk_wdata(bk_wdata), .bk_ack(bk_ack), .bk_rdata(bk_rdata),
      .bus_err(bus_err)
   );

   z80_bus_responder #(.INT_VECTOR(8'hFF), .TIMEOUT(TMO), .IO_ENABLE(0)) dut_noio (
      .clk(clk), .reset(reset), .A(A), .dout(dout),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .di(n_di), .wait_n(n_wait_n), .bk_req(n_bk_req), .bk_we(n_bk_we), .bk_io(n_bk_io),
      .bk_addr(n_bk_addr), .bk_wdata(n_bk_wdata), .bk_ack(bk_ack), .bk_rdata(bk_rdata),
      .bus_err(n_bus_err)
   );

   typedef struct {
      int          cls;
      logic [15:0] addr;
      logic [7:0]  data;
      int          lat;
      logic [7:0]  rdata;
      int          gap;
      int          e_reqcyc;
      int          e_wait;
      logic [7:0]  e_di;
      int          e_err;
      int          n_reqcyc;
      int          n_wait;
      logic [7:0]  n_di;
   } vec_t;

   typedef struct {
      int         reqcyc;
      int         waitc;
      logic [7:0] di;
      int         err;
   } exp_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: what one CPU cycle should cost and return.
   function automatic exp_t model(input int cls, input bit io_en, input int lat,
                                  input logic [7:0] rd, input logic [7:0] prev);
      exp_t e;
      bit   is_mem  = (cls == C_FETCH) || (cls == C_MEMRD) || (cls == C_MEMWR);
      bit   is_io   = (cls == C_IORD) || (cls == C_IOWR);
      bit   is_read = (cls == C_FETCH) || (cls == C_MEMRD) || (cls == C_IORD);
      e = '{reqcyc: 0, waitc: 0, di: prev, err: 0};
      if (is_mem || (is_io && io_en)) begin
         if (lat > TMO) begin
            e.reqcyc = TMO;
            e.err    = 1;
            e.di     = 8'hFF;
         end else begin
            e.reqcyc = lat;
            if (is_read) e.di = rd;
         end
         e.waitc = 1 + e.reqcyc;
      end else if (cls == C_INTA) begin
         e.waitc = 1;
         e.di    = 8'hFF;
      end else if (is_io) begin
         e.waitc = 1;
         if (cls == C_IORD) e.di = 8'hFF;
      end
      return e;
   endfunction

   task automatic drive_cls(input int cls, input logic [15:0] a, input logic [7:0] d);
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
      A = a; dout = d;
      case (cls)
         C_FETCH:   begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
         C_MEMRD:   begin mreq_n = 1'b0; rd_n = 1'b0; end
         C_MEMWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
         C_IORD:    begin iorq_n = 1'b0; rd_n = 1'b0; end
         C_IOWR:    begin iorq_n = 1'b0; wr_n = 1'b0; end
         C_INTA:    begin m1_n = 1'b0; iorq_n = 1'b0; end
         C_REFRESH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
         default: ;
      endcase
   endtask

   // Runs one CPU cycle: strobes held for WINDOW clocks, the backing store
   // acks in the lat-th cycle of bk_req, results reported per instance.
   task automatic run_cycle(input int cls, input logic [15:0] a, input logic [7:0] d,
                            input int lat, input logic [7:0] rd, input int gap,
                            output exp_t got_d, output exp_t got_n,
                            output int reqs_d, output int reqs_n);
      bit         pd = 1'b0, pn = 1'b0;
      logic [25:0] fld;
      fld = {(cls == C_MEMWR) || (cls == C_IOWR), (cls == C_IORD) || (cls == C_IOWR), a, d};
      got_d = '{reqcyc: 0, waitc: 0, di: 8'h00, err: 0};
      got_n = '{reqcyc: 0, waitc: 0, di: 8'h00, err: 0};
      reqs_d = 0; reqs_n = 0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         drive_cls(C_NONE, A, dout);
      end
      @(negedge clk);
      drive_cls(cls, a, d);
      bk_rdata = rd;
      for (int i = 0; i < WINDOW; i++) begin
         if (i > 0) @(negedge clk);
         bk_ack = 1'b0;
         #1;
         if (!wait_n) got_d.waitc++;
         if (!n_wait_n) got_n.waitc++;
         if (bus_err) got_d.err++;
         if (n_bus_err) got_n.err++;
         if (bk_req) begin
            got_d.reqcyc++;
            if (!pd) reqs_d++;
            chk("bk_fields", {6'd0, bk_we, bk_io, bk_addr, bk_wdata}, {6'd0, fld});
         end
         if (n_bk_req) begin
            got_n.reqcyc++;
            if (!pn) reqs_n++;
         end
         pd = bk_req;
         pn = n_bk_req;
         bk_ack = bk_req && (got_d.reqcyc == lat);
      end
      got_d.di = di;
      got_n.di = n_di;
      @(negedge clk);
      bk_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[$];
      exp_t       gd, gn, ed, en;
      int         rq_d, rq_n;
      logic [7:0] prev_d, prev_n;
      bit         seen;

      reset = 1'b1; bk_ack = 1'b0; bk_rdata = 8'h00;
      drive_cls(C_NONE, 16'h0000, 8'h00);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bk_req", bk_req, 1'b0);
      chk("rst_bk_we", bk_we, 1'b0);
      chk("rst_bk_io", bk_io, 1'b0);
      chk("rst_bk_addr", bk_addr, 16'h0000);
      chk("rst_bk_wdata", bk_wdata, 8'h00);
      chk("rst_di", di, 8'h00);
      chk("rst_wait_n", wait_n, 1'b1);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_noio_di", n_di, 8'h00);
      reset = 1'b0;

      //            cls        addr      data   lat rdata  gap  dreq dwait ddi    derr nreq nwait ndi
      vecs.push_back('{C_FETCH,   16'h0000, 8'h00, 2,  8'hCB, 1,   2,   3,   8'hCB, 0,   2,   3,   8'hCB});
      vecs.push_back('{C_MEMWR,   16'h5EA2, 8'h7E, 1,  8'h00, 1,   1,   2,   8'hCB, 0,   1,   2,   8'hCB});
      vecs.push_back('{C_IORD,    16'h0034, 8'h00, 1,  8'h5A, 1,   1,   2,   8'h5A, 0,   0,   1,   8'hFF});
      vecs.push_back('{C_INTA,    16'h0000, 8'h00, 1,  8'h00, 1,   0,   1,   8'hFF, 0,   0,   1,   8'hFF});
      vecs.push_back('{C_REFRESH, 16'h0002, 8'h00, 1,  8'h00, 0,   0,   0,   8'hFF, 0,   0,   0,   8'hFF});
      vecs.push_back('{C_MEMRD,   16'h1234, 8'h00, 99, 8'h77, 1,   16,  17,  8'hFF, 1,   16,  17,  8'hFF});
      vecs.push_back('{C_MEMRD,   16'hABCD, 8'h00, 16, 8'h3C, 1,   16,  17,  8'h3C, 0,   16,  17,  8'h3C});
      vecs.push_back('{C_IOWR,    16'h0080, 8'h11, 3,  8'h00, 1,   3,   4,   8'h3C, 0,   0,   1,   8'h3C});
      vecs.push_back('{C_FETCH,   16'h0100, 8'h00, 1,  8'h21, 1,   1,   2,   8'h21, 0,   1,   2,   8'h21});
      vecs.push_back('{C_REFRESH, 16'h0003, 8'h00, 1,  8'h00, 0,   0,   0,   8'h21, 0,   0,   0,   8'h21});
      vecs.push_back('{C_MEMRD,   16'h0101, 8'h00, 4,  8'h99, 0,   4,   5,   8'h99, 0,   4,   5,   8'h99});

      foreach (vecs[k]) begin
         run_cycle(vecs[k].cls, vecs[k].addr, vecs[k].data, vecs[k].lat, vecs[k].rdata,
                   vecs[k].gap, gd, gn, rq_d, rq_n);
         chk($sformatf("v%0d_reqs", k), rq_d, (vecs[k].e_reqcyc > 0) ? 1 : 0);
         chk($sformatf("v%0d_reqcyc", k), gd.reqcyc, vecs[k].e_reqcyc);
         chk($sformatf("v%0d_wait", k), gd.waitc, vecs[k].e_wait);
         chk($sformatf("v%0d_di", k), gd.di, vecs[k].e_di);
         chk($sformatf("v%0d_err", k), gd.err, vecs[k].e_err);
         chk($sformatf("v%0d_noio_reqs", k), rq_n, (vecs[k].n_reqcyc > 0) ? 1 : 0);
         chk($sformatf("v%0d_noio_reqcyc", k), gn.reqcyc, vecs[k].n_reqcyc);
         chk($sformatf("v%0d_noio_wait", k), gn.waitc, vecs[k].n_wait);
         chk($sformatf("v%0d_noio_di", k), gn.di, vecs[k].n_di);
      end

      prev_d = 8'h99;
      prev_n = 8'h99;
      for (int r = 0; r < 40; r++) begin
         int          cls, lat, gap;
         logic [15:0] a;
         logic [7:0]  d, rd;
         cls = int'($urandom_range(C_FETCH, C_REFRESH));
         lat = int'($urandom_range(1, TMO + 3));
         gap = (cls == C_REFRESH) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         a   = 16'($urandom());
         d   = 8'($urandom());
         rd  = 8'($urandom());
         ed = model(cls, 1'b1, lat, rd, prev_d);
         en = model(cls, 1'b0, lat, rd, prev_n);
         run_cycle(cls, a, d, lat, rd, gap, gd, gn, rq_d, rq_n);
         chk($sformatf("r%0d_reqs", r), rq_d, (ed.reqcyc > 0) ? 1 : 0);
         chk($sformatf("r%0d_reqcyc", r), gd.reqcyc, ed.reqcyc);
         chk($sformatf("r%0d_wait", r), gd.waitc, ed.waitc);
         chk($sformatf("r%0d_di", r), gd.di, ed.di);
         chk($sformatf("r%0d_err", r), gd.err, ed.err);
         chk($sformatf("r%0d_noio_reqcyc", r), gn.reqcyc, en.reqcyc);
         chk($sformatf("r%0d_noio_wait", r), gn.waitc, en.waitc);
         chk($sformatf("r%0d_noio_di", r), gn.di, en.di);
         chk($sformatf("r%0d_noio_err", r), gn.err, en.err);
         prev_d = ed.di;
         prev_n = en.di;
      end

      // Reset in the middle of a request, with a late ack right after it.
      @(negedge clk);
      drive_cls(C_NONE, 16'h0000, 8'h00);
      @(negedge clk);
      drive_cls(C_MEMRD, 16'h4444, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = bk_req;
      end
      chk("midreq_bk_req_seen", seen, 1'b1);
      reset = 1'b1;
      drive_cls(C_NONE, 16'h0000, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      bk_ack = 1'b1;
      #1;
      chk("midreq_bk_req", bk_req, 1'b0);
      chk("midreq_wait_n", wait_n, 1'b1);
      chk("midreq_di", di, 8'h00);
      @(negedge clk);
      bk_ack = 1'b0;
      #1;
      chk("midreq_ack_ignored_req", bk_req, 1'b0);
      chk("midreq_ack_ignored_di", di, 8'h00);
      chk("midreq_bus_err", bus_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameter INT_VECTOR, default 8'hFF, byte returned on interrupt-acknowledge cycles.
REQ-002 Parameter TIMEOUT, default 16, max cycles bk_req may wait for bk_ack before abort.
REQ-003 Parameter IO_ENABLE, default 1; 0 = I/O cycles never reach backing store.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 A  in  16  CPU address; dout  in  8  CPU write data.
REQ-007 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes, active-low.
REQ-008 di  out  8  read data to CPU; wait_n  out  1  CPU wait request, active-low.
REQ-009 bk_req  out  1; bk_we  out  1; bk_io  out  1; bk_addr  out  16; bk_wdata  out  8  backing-store request.
REQ-010 bk_ack  in  1; bk_rdata  in  8  backing-store completion and read data.
REQ-011 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-012 Cycle classes: MEMRD = !mreq_n & !rd_n & rfsh_n; MEMWR = !mreq_n & !wr_n; IORD = !iorq_n & !rd_n & m1_n; IOWR = !iorq_n & !wr_n; INTA = !iorq_n & !m1_n; REFRESH = !rfsh_n; otherwise NONE.
REQ-013 FSM states IDLE, REQ, HOLD; REQ also tracks a timeout counter.
REQ-014 IDLE: on MEMRD/MEMWR/IORD/IOWR (IO only if IO_ENABLE), capture A, dout, we, io into bk_* regs, assert bk_req next cycle, go REQ.
REQ-015 IDLE: on INTA, load di=INT_VECTOR, go HOLD, no backing request.
REQ-016 IDLE: on IORD with IO_ENABLE=0, load di=8'hFF, go HOLD; on IOWR with IO_ENABLE=0, go HOLD, write discarded.
REQ-017 REFRESH and NONE produce no request and no state change.
REQ-018 REQ: bk_req=1, bk_addr/bk_we/bk_io/bk_wdata held stable until bk_ack sampled high.
REQ-019 bk_ack sampled high in REQ (including first REQ cycle): bk_req=0 next cycle; for reads di=bk_rdata; go HOLD.
REQ-020 Exactly one backing request per CPU bus cycle; bk_ack outside REQ is ignored.
REQ-021 Timeout counter clears on entry to REQ, increments each REQ cycle without ack; at TIMEOUT: drop bk_req, di=8'hFF, pulse bus_err, go HOLD.
REQ-022 HOLD: di held; return to IDLE when class is NONE or REFRESH (strobes released).
REQ-023 wait_n = 0 combinationally while a serviceable class is active in IDLE, and throughout REQ; wait_n = 1 in HOLD and otherwise.
REQ-024 di retains last value outside read cycles; di is never X after reset.
REQ-025 Back-to-back cycles (M1 fetch then refresh then next access) require HOLD->IDLE before next capture; no strobe edge is lost if released for at least one clk.

Reset
REQ-026 reset: state=IDLE, bk_req=0, bk_we=0, bk_io=0, bk_addr=0, bk_wdata=0, di=8'h00, wait_n=1, bus_err=0, counter=0.
REQ-027 reset mid-REQ aborts the transfer; bk_ack arriving after reset is ignored.

Structure
REQ-028 Package z80_bus_pkg holds the FSM state enum, cycle-class enum, and classification constants.
REQ-029 One sub-module z80_cycle_decode: combinational strobe-to-class decoder per REQ-012.

Verification
REQ-030 M1 fetch A=16'h0000, backing data 8'hCB, bk_ack 2 cycles after bk_req -> wait_n low 3 cycles, di=8'hCB, one bk_req, bk_we=0.
REQ-031 MEMWR A=16'h5EA2, dout=8'h7E, ack immediate -> bk_addr=16'h5EA2, bk_wdata=8'h7E, bk_we=1, single request.
REQ-032 IORD port 16'h0034, bk_rdata=8'h5A -> bk_io=1, di=8'h5A; repeat with IO_ENABLE=0 -> no bk_req, di=8'hFF.
REQ-033 INTA cycle -> di=8'hFF (INT_VECTOR), no bk_req; REFRESH cycle at A=16'h0002 -> no bk_req, wait_n stays 1.
REQ-034 MEMRD with bk_ack never asserted -> bk_req drops after 16 cycles, bus_err one-cycle pulse, di=8'hFF, wait_n released.
REQ-035 reset asserted during REQ, bk_ack asserted next cycle -> IDLE, bk_req=0, wait_n=1, di=8'h00, ack ignored.
